// File: rtl/spm_pkg.sv
// Shared widths and state encoding for the serial-parallel multiplier and its
// downstream negation stage.
package spm_pkg;

   localparam int SPM_WIDTH  = 8;
   localparam int SPM_PWIDTH = 2 * SPM_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } spm_state_e;

endpackage : spm_pkg

// File: rtl/spm_mag_multiplier_if.sv
// Operand/result bundle of the multiplier core: the requester drives the
// operands and start, and the core returns status and the product magnitude.
interface spm_mag_multiplier_if
   import spm_pkg::*;
#(
   parameter int WIDTH = SPM_WIDTH
);

   localparam int PWIDTH = 2 * WIDTH - 1;

   logic              start;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              busy;
   logic              done;
   logic [PWIDTH-1:0] p_mag;
   logic              p_neg;

   modport master (
      output start, a, b,
      input  busy, done, p_mag, p_neg
   );

   modport slave (
      input  start, a, b,
      output busy, done, p_mag, p_neg
   );

endinterface : spm_mag_multiplier_if

// File: rtl/spm_abs.sv
// Two's-complement magnitude as an unsigned value of the same width; the most
// negative input maps to 2**(WIDTH-1), which still fits unsigned.
module spm_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] mag
);

   assign mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

endmodule : spm_abs

// File: rtl/spm_mag_multiplier.sv
// Shift-add multiplier core: one multiplier bit per clock, emitting |a|*|b|
// and a negate flag for the downstream two's-complement stage.
module spm_mag_multiplier
   import spm_pkg::*;
#(
   parameter int WIDTH = SPM_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   spm_mag_multiplier_if.slave   bus
);

   localparam int PWIDTH = 2 * WIDTH - 1;
   localparam int CW     = $clog2(WIDTH);

   spm_state_e          state;
   logic [WIDTH-1:0]    abs_a;
   logic [WIDTH-1:0]    abs_b;
   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;
   logic                sgn;
   logic [CW-1:0]       count;
   logic [2*WIDTH-1:0]  acc;
   logic [2*WIDTH-1:0]  acc_next;
   logic [WIDTH:0]      sum;
   logic                busy_q;
   logic                done_q;
   logic [PWIDTH-1:0]   p_mag_q;
   logic                p_neg_q;

   spm_abs #(.WIDTH(WIDTH)) u_abs_a (.value(bus.a), .mag(abs_a));
   spm_abs #(.WIDTH(WIDTH)) u_abs_b (.value(bus.b), .mag(abs_b));

   // One iteration: conditional add into the upper half (keeping the carry),
   // then shift the whole accumulator right with the carry entering the top.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (mag_b[0]) begin
         sum = sum + {1'b0, mag_a};
      end
      acc_next = {sum, acc[WIDTH-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mag_a   <= '0;
         mag_b   <= '0;
         sgn     <= 1'b0;
         count   <= '0;
         acc     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_mag_q <= '0;
         p_neg_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  mag_a  <= abs_a;
                  mag_b  <= abs_b;
                  sgn    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  acc    <= '0;
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               acc   <= acc_next;
               mag_b <= mag_b >> 1;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  state   <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  p_mag_q <= acc_next[PWIDTH-1:0];
                  // A zero product is never reported as negative.
                  p_neg_q <= sgn & (|acc_next);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.p_mag = p_mag_q;
   assign bus.p_neg = p_neg_q;

endmodule : spm_mag_multiplier

// File: tb/tb_spm_mag_multiplier.sv
// Scoreboard bench for spm_mag_multiplier: the driver queues expected results
// and done cycles, and a negedge monitor checks every done pulse against them.
module tb_spm_mag_multiplier;
   import spm_pkg::*;

   typedef struct {
      logic [SPM_PWIDTH-1:0] p_mag;
      logic                  p_neg;
      int                    done_cyc;
      string                 name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   logic prev_done;
   exp_t sb[$];

   spm_mag_multiplier_if #(.WIDTH(SPM_WIDTH)) bus ();

   spm_mag_multiplier #(.WIDTH(SPM_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.done) begin
         check("done_single_cycle", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(bus.done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_p_mag"}, 32'(bus.p_mag), 32'(e.p_mag));
            check({e.name, "_p_neg"}, 32'(bus.p_neg), 32'(e.p_neg));
            check({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
         end
      end
      prev_done = bus.done;
   end

   // Drive one start pulse and queue the expected response; returns #1 after
   // the edge that sampled start.
   task automatic issue(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic [SPM_PWIDTH-1:0] pm, input logic pn);
      exp_t e;
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1;
      e.p_mag    = pm;
      e.p_neg    = pn;
      e.done_cyc = cyc + SPM_WIDTH;
      e.name     = name;
      sb.push_back(e);
      bus.start  = 1'b0;
      bus.a      = ~av;
      bus.b      = ~bv;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (bus.done) break;
         n++;
      end
      if (n >= budget) check({name, "_timeout"}, 32'(bus.done), 32'd1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      prev_done = 1'b0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("reset_busy",  32'(bus.busy),  32'd0);
      check("reset_done",  32'(bus.done),  32'd0);
      check("reset_p_mag", 32'(bus.p_mag), 32'd0);
      check("reset_p_neg", 32'(bus.p_neg), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 5*3: busy for exactly eight cycles, then outputs hold.
      issue("mul_5x3", 8'd5, 8'd3, 15'd15, 1'b0);
      for (int i = 0; i < SPM_WIDTH; i++) begin
         @(negedge clk);
         check("busy_running", 32'(bus.busy), 32'd1);
      end
      @(negedge clk);
      check("busy_after_done", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      check("hold_p_mag", 32'(bus.p_mag), 32'd15);
      check("idle_done",  32'(bus.done),  32'd0);

      issue("mul_m7x9", 8'hF9, 8'd9, 15'd63, 1'b1);
      wait_done("mul_m7x9", 20);
      check("downstream_neg63", 32'((~bus.p_mag + 15'd1) & 15'h7FFF), 32'h7FC1);

      issue("mul_m128xm128", 8'h80, 8'h80, 15'h4000, 1'b0);
      wait_done("mul_m128xm128", 20);
      issue("mul_m128x127", 8'h80, 8'h7F, 15'd16256, 1'b1);
      wait_done("mul_m128x127", 20);
      issue("mul_0xm5", 8'd0, 8'hFB, 15'd0, 1'b0);
      wait_done("mul_0xm5", 20);
      issue("mul_m1xm1", 8'hFF, 8'hFF, 15'd1, 1'b0);
      wait_done("mul_m1xm1", 20);

      // Start during RUN is ignored; start during DONE chains immediately.
      issue("mul_6x7", 8'd6, 8'd7, 15'd42, 1'b0);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'd20;
      bus.b     = 8'd20;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("mul_6x7", 20);
      issue("mul_11xm3_b2b", 8'd11, 8'hFD, 15'd33, 1'b1);
      wait_done("mul_11xm3_b2b", 20);

      // Asynchronous reset mid-operation discards the result.
      @(negedge clk);
      issue("mul_9x9_aborted", 8'd9, 8'd9, 15'd81, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy",  32'(bus.busy),  32'd0);
      check("abort_done",  32'(bus.done),  32'd0);
      check("abort_p_mag", 32'(bus.p_mag), 32'd0);
      check("abort_p_neg", 32'(bus.p_neg), 32'd0);
      void'(sb.pop_back());
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      issue("mul_2x2", 8'd2, 8'd2, 15'd4, 1'b0);
      wait_done("mul_2x2", 20);

      repeat (3) @(negedge clk);
      check("final_queue_empty", 32'(sb.size()), 32'd0);
      check("final_busy", 32'(bus.busy), 32'd0);
      check("final_done", 32'(bus.done), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spm_mag_multiplier

// File: doc/spm_mag_multiplier.md
Name: spm_mag_multiplier

Overview:
- Sequential shift-add core of the 8-bit serial-parallel multiplier (SPM); sits directly upstream of the 15-bit two's-complement stage.
- Captures two signed 8-bit operands and converts them to magnitudes.
- Processes one multiplier bit per clock and produces a 15-bit product magnitude plus a negate flag.
- Downstream logic selects either the magnitude or its two's complement based on that flag, giving the signed product.

Parameters:
- WIDTH, 8, operand width in bits (two's complement).
- PWIDTH, 2*WIDTH-1 = 15, product magnitude width. Derived; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled on the rising edge.
- a  input  WIDTH  multiplicand, signed.
- b  input  WIDTH  multiplier, signed.
- busy  output  1  high while an iteration sequence is running.
- done  output  1  one-cycle pulse; product outputs are valid from this cycle onward.
- p_mag  output  PWIDTH  product magnitude, |a|*|b|.
- p_neg  output  1  high when the signed product is negative; drives the downstream negation select.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, p_mag=0, p_neg=0.
  - Counter, accumulator and operand registers are cleared.
  - Any in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE, with start=1 on an edge:
  - Latch mag_a=|a| and mag_b=|b| as WIDTH-bit unsigned values. |-128| = 128 = 8'h80 is valid unsigned.
  - Latch sgn=a[7]^b[7]; clear the 2*WIDTH-bit accumulator; count=0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge (one iteration):
  - If mag_b[0]=1, add mag_a to the upper WIDTH+1 bits of the accumulator, carry included.
  - Shift the accumulator right by 1; shift mag_b right by 1; count++.
  - After iteration WIDTH (count reaches WIDTH-1 at the start of the edge), go to DONE.
  - On that same edge:
    - p_mag <= acc[PWIDTH-1:0]. Bit 15 is always 0; max 128*128=16384=15'h4000.
    - p_neg <= sgn & (product != 0). Zero is never negative.
    - done <= 1; busy <= 0.
- Latency: start sampled at edge k -> done=1 and p_mag/p_neg valid after edge k+WIDTH (8 cycles).
- DONE:
  - done is high for exactly one cycle. With no new start, the next edge returns to IDLE with done=0.
  - p_mag/p_neg hold their value until the next completed operation or reset.
- start while in RUN is ignored (no queuing); a, b, start changes have no effect on the operation in progress.
- start in DONE begins a new operation immediately (back-to-back throughput: one result per WIDTH+1 cycles).
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Package spm_pkg holds:
  - SPM_WIDTH=8 and SPM_PWIDTH=15;
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The downstream negation stage shares these widths.
- One sub-module is natural: spm_abs (WIDTH in, WIDTH out, unsigned magnitude), instantiated twice at operand capture.
- Shift-add datapath and FSM stay in this module.

Test Plan:
- After reset, a=5, b=3, start pulse -> done exactly 8 cycles later; p_mag=15, p_neg=0; busy high for those 8 cycles.
- a=-7 (8'hF9), b=9 -> p_mag=63, p_neg=1. Downstream two's complement of 63 gives 15'h7FC1.
- a=-128, b=-128 -> p_mag=16384 (15'h4000), p_neg=0. a=-128, b=127 -> p_mag=16256, p_neg=1.
- a=0, b=-5 -> p_mag=0, p_neg=0 (zero not negative). a=-1, b=-1 -> p_mag=1, p_neg=0.
- start=1 with new operands (20,20) at cycle 3 of a running 6*7 multiply -> ignored; result p_mag=42. start asserted in the DONE cycle -> second result arrives 8 cycles later.
- Assert rst at cycle 4 of a multiply -> all outputs 0 immediately (asynchronously), no done pulse. After release, 2*2 completes with p_mag=4.
